// File: rtl/dds_spi_pkg.sv
// dds_spi_pkg: shared types and widths for the DDS serial-port slave
package dds_spi_pkg;
  typedef enum logic [1:0] {IDLE, INSTR, WDATA, RDATA} state_t;
  localparam int INSTR_W = 8;
  localparam int RD_BIT  = 7;
  localparam int ADDR_W  = 5;
  localparam int DW_DEF  = 32;
endpackage

// File: rtl/dds_serial_slave_sync_edge.sv
// sync_edge: 2-flop synchronizer with rise/fall flags of the synchronized level
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);
  logic r_s1, r_s2, r_prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) {r_s1, r_s2, r_prev} <= '0;
    else {r_s1, r_s2, r_prev} <= {i_d, r_s1, r_s2};
  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_prev;
  assign o_fall = ~r_s2 & r_prev;
endmodule

// File: rtl/dds_serial_slave.sv
// dds_serial_slave: DDS-side serial port responder with buffer/active register banks
module dds_serial_slave
  import dds_spi_pkg::*;
#(
  parameter int              NREG    = 8,
  parameter int              DW      = DW_DEF,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              CS,
  input  logic              SDIO,
  input  logic              SYNCIO,
  input  logic              IO_UPDATE,
  output logic              SDO,
  output logic              SDO_OE,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              upd_pulse,
  input  logic [2:0]        dbg_addr,
  output logic [DW-1:0]     dbg_data
);
  localparam int AW = $clog2(NREG);
  logic [4:0] w_pin, w_q, w_rise, w_fall;
  logic       w_unused;
  assign w_pin = {IO_UPDATE, SYNCIO, SDIO, CS, SCLK};
  for (genvar g = 0; g < 5; g++) begin : g_sync
    sync_edge u_sync (
      .clk   (clk),
      .rst   (rst),
      .i_d   (w_pin[g]),
      .o_q   (w_q[g]),
      .o_rise(w_rise[g]),
      .o_fall(w_fall[g])
    );
  end
  logic w_srise, w_sfall, w_cs, w_sdio, w_sync, w_upd;
  assign w_srise  = w_rise[0];
  assign w_sfall  = w_fall[0];
  assign w_cs     = w_q[1];
  assign w_sdio   = w_q[2];
  assign w_sync   = w_q[3];
  assign w_upd    = w_rise[4];
  assign w_unused = ^{w_q[0], w_q[4], w_rise[3:1], w_fall[4:1]};

  state_t              r_state;
  logic [5:0]          r_cnt;
  logic [INSTR_W-2:0]  r_sh;
  logic [ADDR_W-1:0]   r_addr;
  logic [DW-1:0]       r_wdata, r_rsh;
  logic                r_commit, r_done;
  logic [DW-1:0]       r_buf [NREG];
  logic [DW-1:0]       r_act [NREG];
  logic [DW-1:0]       w_buf_nxt [NREG];
  logic [INSTR_W-1:0]  w_instr;
  logic [DW-1:0]       w_rd_val;
  logic                w_abort, w_wr;

  assign w_abort  = w_cs | w_sync;
  assign w_instr  = {r_sh, w_sdio};
  assign w_rd_val = (32'(w_instr[ADDR_W-1:0]) < NREG) ? r_act[w_instr[AW-1:0]] : '0;
  assign w_wr     = (r_state == WDATA) && r_commit && !w_abort && (32'(r_addr) < NREG);
  assign dbg_data = r_act[dbg_addr[AW-1:0]];

  // Commit and update in the same cycle: active must see the freshly committed word
  always_comb begin
    w_buf_nxt = r_buf;
    if (w_wr) w_buf_nxt[r_addr[AW-1:0]] = r_wdata;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_buf[i] <= RST_VAL;
        r_act[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_buf[i] <= w_buf_nxt[i];
        if (w_upd) r_act[i] <= w_buf_nxt[i];
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rsh     <= '0;
      r_commit  <= 1'b0;
      r_done    <= 1'b0;
      SDO       <= 1'b0;
      SDO_OE    <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      upd_pulse <= 1'b0;
    end else begin
      wr_valid  <= w_wr;
      upd_pulse <= w_upd;
      if (w_wr) begin
        wr_addr <= r_addr;
        wr_data <= r_wdata;
      end
      if (w_abort) begin
        r_state  <= w_cs ? IDLE : INSTR;
        r_cnt    <= '0;
        r_commit <= 1'b0;
        r_done   <= 1'b0;
        SDO      <= 1'b0;
        SDO_OE   <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= INSTR;
            r_cnt   <= '0;
          end
          INSTR: if (w_srise) begin
            r_sh  <= w_instr[INSTR_W-2:0];
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(INSTR_W - 1)) begin
              r_cnt   <= '0;
              r_addr  <= w_instr[ADDR_W-1:0];
              r_state <= w_instr[RD_BIT] ? RDATA : WDATA;
              r_rsh   <= w_rd_val;
            end
          end
          WDATA: if (r_commit) begin
            r_commit <= 1'b0;
            r_state  <= INSTR;
            r_cnt    <= '0;
          end else if (w_srise) begin
            r_wdata  <= {r_wdata[DW-2:0], w_sdio};
            r_cnt    <= r_cnt + 6'd1;
            r_commit <= (r_cnt == 6'(DW - 1));
          end
          RDATA: if (w_sfall) begin
            if (r_done) begin
              SDO     <= 1'b0;
              SDO_OE  <= 1'b0;
              r_done  <= 1'b0;
              r_state <= INSTR;
              r_cnt   <= '0;
            end else if (!SDO_OE) begin
              SDO    <= r_rsh[DW-1];
              SDO_OE <= 1'b1;
            end else begin
              r_rsh <= r_rsh << 1;
              SDO   <= r_rsh[DW-2];
            end
          end else if (w_srise) begin
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(DW - 1)) r_done <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
endmodule
